// File: rtl/fix_msg_tx.sv
// FIX 4.2 header/trailer byte serializer with valid/ready output handshake.
// Optional checksum trailer ("10=CCC" SOH) is built only when FIX_TX_CHECKSUM_EN is defined.
module fix_msg_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_i,
  input  logic [7:0] msg_type_i,
  input  logic [7:0] seq_num_i,
  input  logic       ready_i,
  output logic [7:0] message_o,
  output logic       send_message_valid_o,
  output logic       busy_o,
  output logic       done_o
);

`ifdef FIX_TX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, BODY, CKSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, BODY, DONE} state_t;
`endif

  localparam logic [5:0] BODY_LAST = 6'd26;
`ifdef FIX_TX_CHECKSUM_EN
  localparam logic [5:0] MSG_LAST  = 6'd33;
`endif
  localparam logic [7:0] SOH       = 8'h01;

  state_t     state;
  logic [5:0] idx;
  logic [7:0] msg_type_q;
  logic [7:0] seq_d2, seq_d1, seq_d0;
  logic [5:0] nxt_idx;
  logic [7:0] nxt_byte;
  logic       xfer;

`ifdef FIX_TX_CHECKSUM_EN
  logic [7:0] cksum;
  logic [7:0] ck_d2, ck_d1, ck_d0;

  // The register already holds the full body sum once the trailer digits are reached.
  always_comb begin
    ck_d2 = 8'h30 + cksum / 8'd100;
    ck_d1 = 8'h30 + (cksum / 8'd10) % 8'd10;
    ck_d0 = 8'h30 + cksum % 8'd10;
  end
`endif

  assign xfer = send_message_valid_o && ready_i;

  // Byte to present after the next transfer (or the first byte when idle).
  always_comb begin
    nxt_idx  = (state == IDLE) ? '0 : idx + 6'd1;
    nxt_byte = SOH;
    case (nxt_idx)
      6'd0:  nxt_byte = "8";
      6'd1:  nxt_byte = "=";
      6'd2:  nxt_byte = "F";
      6'd3:  nxt_byte = "I";
      6'd4:  nxt_byte = "X";
      6'd5:  nxt_byte = ".";
      6'd6:  nxt_byte = "4";
      6'd7:  nxt_byte = ".";
      6'd8:  nxt_byte = "2";
      6'd10: nxt_byte = "9";
      6'd11: nxt_byte = "=";
      6'd12: nxt_byte = "1";
      6'd13: nxt_byte = "2";
      6'd15: nxt_byte = "3";
      6'd16: nxt_byte = "5";
      6'd17: nxt_byte = "=";
      6'd18: nxt_byte = msg_type_q;
      6'd20: nxt_byte = "3";
      6'd21: nxt_byte = "4";
      6'd22: nxt_byte = "=";
      6'd23: nxt_byte = seq_d2;
      6'd24: nxt_byte = seq_d1;
      6'd25: nxt_byte = seq_d0;
`ifdef FIX_TX_CHECKSUM_EN
      6'd27: nxt_byte = "1";
      6'd28: nxt_byte = "0";
      6'd29: nxt_byte = "=";
      6'd30: nxt_byte = ck_d2;
      6'd31: nxt_byte = ck_d1;
      6'd32: nxt_byte = ck_d0;
`endif
      default: nxt_byte = SOH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      idx                  <= '0;
      msg_type_q           <= '0;
      seq_d2               <= '0;
      seq_d1               <= '0;
      seq_d0               <= '0;
      message_o            <= '0;
      send_message_valid_o <= 1'b0;
      busy_o               <= 1'b0;
      done_o               <= 1'b0;
`ifdef FIX_TX_CHECKSUM_EN
      cksum                <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (send_i) begin
            msg_type_q           <= msg_type_i;
            seq_d2               <= 8'h30 + seq_num_i / 8'd100;
            seq_d1               <= 8'h30 + (seq_num_i / 8'd10) % 8'd10;
            seq_d0               <= 8'h30 + seq_num_i % 8'd10;
            idx                  <= nxt_idx;
            message_o            <= nxt_byte;
            send_message_valid_o <= 1'b1;
            busy_o               <= 1'b1;
`ifdef FIX_TX_CHECKSUM_EN
            cksum                <= '0;
`endif
            state                <= BODY;
          end
        end
        BODY: begin
          if (xfer) begin
`ifdef FIX_TX_CHECKSUM_EN
            cksum     <= cksum + message_o;
            idx       <= nxt_idx;
            message_o <= nxt_byte;
            if (idx == BODY_LAST) state <= CKSUM;
`else
            if (idx == BODY_LAST) begin
              state                <= DONE;
              idx                  <= '0;
              message_o            <= '0;
              send_message_valid_o <= 1'b0;
              done_o               <= 1'b1;
            end else begin
              idx       <= nxt_idx;
              message_o <= nxt_byte;
            end
`endif
          end
        end
`ifdef FIX_TX_CHECKSUM_EN
        CKSUM: begin
          if (xfer) begin
            if (idx == MSG_LAST) begin
              state                <= DONE;
              idx                  <= '0;
              message_o            <= '0;
              send_message_valid_o <= 1'b0;
              done_o               <= 1'b1;
            end else begin
              idx       <= nxt_idx;
              message_o <= nxt_byte;
            end
          end
        end
`endif
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
